// File: rtl/serial_mag_comparator_pkg.sv
// Shared types and result encoding for the serial magnitude comparator.
// Optional signed mode is selected with the SERIAL_CMP_SIGNED_EN macro.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } stateT;

    // Result flags packed as {a_gt_b, a_lt_b, a_eq_b}; one-hot once decided.
    localparam logic [2:0] GT   = 3'b100;
    localparam logic [2:0] LT   = 3'b010;
    localparam logic [2:0] EQ   = 3'b001;
    localparam logic [2:0] NONE = 3'b000;

endpackage

// File: rtl/serial_mag_comparator_if.sv
// Start/done handshake and operand/result bundle for serial_mag_comparator.
// With SERIAL_CMP_SIGNED_EN defined the bundle carries the sgn select.
interface serial_mag_comparator_if #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
);
    localparam int STEPW = $clog2(WIDTH / DIGIT + 1);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_CMP_SIGNED_EN
    logic             sgn;
`endif
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;
    logic [STEPW-1:0] steps;

    modport master (
`ifdef SERIAL_CMP_SIGNED_EN
        output sgn,
`endif
        output start, a, b,
        input  busy, done, a_gt_b, a_lt_b, a_eq_b, steps
    );

    modport slave (
`ifdef SERIAL_CMP_SIGNED_EN
        input  sgn,
`endif
        input  start, a, b,
        output busy, done, a_gt_b, a_lt_b, a_eq_b, steps
    );

endinterface

// File: rtl/serial_mag_comparator_cmp_digit.sv
// Combinational DIGIT-bit magnitude compare; equality is neither gt nor lt.
module cmp_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] digA,
    input  logic [DIGIT-1:0] digB,
    output logic             gt,
    output logic             lt
);

    // Plain unsigned compare of one digit.
    always_comb begin
        gt = (digA > digB);
        lt = (digA < digB);
    end

endmodule

// File: rtl/serial_mag_comparator.sv
// Sequential MSB-first magnitude comparator with early exit on the first
// differing digit. Signed (two's complement) mode via SERIAL_CMP_SIGNED_EN.
//
// state | meaning
// IDLE  | waiting for start; result flags and steps held
// CMP   | comparing one digit per cycle, shifting left while digits match
// DONE  | one-cycle done pulse, result valid
module serial_mag_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    serial_mag_comparator_if.slave cmpIf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int STEPW = $clog2(N + 1);

    stateT            state;
    stateT            stateNext;
    logic [WIDTH-1:0] shA;
    logic [WIDTH-1:0] shB;
    logic [WIDTH-1:0] capA;
    logic [WIDTH-1:0] capB;
    logic [STEPW-1:0] cnt;
    logic [STEPW-1:0] stepReg;
    logic [2:0]       resFlags;
    logic             digGt;
    logic             digLt;
    logic             lastDigit;

    cmp_digit #(.DIGIT(DIGIT)) uDigit (
        .digA (shA[WIDTH-1 -: DIGIT]),
        .digB (shB[WIDTH-1 -: DIGIT]),
        .gt   (digGt),
        .lt   (digLt)
    );

    // Operand capture; signed mode flips each MSB so an unsigned compare orders two's complement.
    always_comb begin
`ifdef SERIAL_CMP_SIGNED_EN
        capA = cmpIf.a ^ (WIDTH'(cmpIf.sgn) << (WIDTH - 1));
        capB = cmpIf.b ^ (WIDTH'(cmpIf.sgn) << (WIDTH - 1));
`else
        capA = cmpIf.a;
        capB = cmpIf.b;
`endif
        lastDigit = (cnt == STEPW'(1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        stateNext   = state;
        cmpIf.busy  = 1'b0;
        cmpIf.done  = 1'b0;
        unique case (state)
            IDLE: if (cmpIf.start) stateNext = CMP;
            CMP: begin
                cmpIf.busy = 1'b1;
                if (digGt || digLt || lastDigit) stateNext = DONE;
            end
            DONE: begin
                cmpIf.done = 1'b1;
                stateNext  = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Shift registers, digit down-counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shA      <= '0;
            shB      <= '0;
            cnt      <= '0;
            stepReg  <= '0;
            resFlags <= NONE;
        end else begin
            case (state)
                IDLE: if (cmpIf.start) begin
                    shA      <= capA;
                    shB      <= capB;
                    cnt      <= STEPW'(N);
                    resFlags <= NONE;
                end
                CMP: begin
                    if (digGt) begin
                        resFlags <= GT;
                        stepReg  <= STEPW'(N) - cnt + STEPW'(1);
                    end else if (digLt) begin
                        resFlags <= LT;
                        stepReg  <= STEPW'(N) - cnt + STEPW'(1);
                    end else if (lastDigit) begin
                        resFlags <= EQ;
                        stepReg  <= STEPW'(N);
                    end else begin
                        shA <= shA << DIGIT;
                        shB <= shB << DIGIT;
                        cnt <= cnt - STEPW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmpIf.a_gt_b = resFlags[2];
    assign cmpIf.a_lt_b = resFlags[1];
    assign cmpIf.a_eq_b = resFlags[0];
    assign cmpIf.steps  = stepReg;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench for serial_mag_comparator (WIDTH=8, DIGIT=1).
// Signed vectors run only when SERIAL_CMP_SIGNED_EN is defined.
module tb_serial_mag_comparator;

    localparam logic [2:0] XGT = 3'b100;
    localparam logic [2:0] XLT = 3'b010;
    localparam logic [2:0] XEQ = 3'b001;

    typedef struct {
        logic [2:0] flags;
        logic [3:0] steps;
        int         doneCyc;
        string      name;
    } expT;

    logic clk;
    logic rst_n;
    int   cycCnt;
    int   checks;
    int   errors;
    expT  sb[$];

    serial_mag_comparator_if #(.WIDTH(8), .DIGIT(1)) cmpIf ();

    serial_mag_comparator #(.WIDTH(8), .DIGIT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmpIf (cmpIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter: value after edge k is k (edge numbering relative to time 0).
    always @(posedge clk) cycCnt <= cycCnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Monitor: every done pulse pops one expectation and compares it.
    always @(negedge clk) begin
        expT e;
        if (cmpIf.done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, required no done", cycCnt);
            end else begin
                e = sb.pop_front();
                checks++;
                if ({cmpIf.a_gt_b, cmpIf.a_lt_b, cmpIf.a_eq_b} !== e.flags) begin
                    errors++;
                    $display("FAIL %s_flags: got %b, required %b", e.name,
                             {cmpIf.a_gt_b, cmpIf.a_lt_b, cmpIf.a_eq_b}, e.flags);
                end
                checks++;
                if (cmpIf.steps !== e.steps) begin
                    errors++;
                    $display("FAIL %s_steps: got %0d, required %0d", e.name, cmpIf.steps, e.steps);
                end
                checks++;
                if (cycCnt != e.doneCyc) begin
                    errors++;
                    $display("FAIL %s_latency: done at cycle %0d, required %0d", e.name, cycCnt, e.doneCyc);
                end
                checks++;
                if (cmpIf.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_busy_at_done: got %b, required 0", e.name, cmpIf.busy);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chkAllZero(input string nm);
        chk({nm, "_busy"},  {7'd0, cmpIf.busy},   8'd0);
        chk({nm, "_done"},  {7'd0, cmpIf.done},   8'd0);
        chk({nm, "_flags"}, {5'd0, cmpIf.a_gt_b, cmpIf.a_lt_b, cmpIf.a_eq_b}, 8'd0);
        chk({nm, "_steps"}, {4'd0, cmpIf.steps},  8'd0);
    endtask

    // Drive one start cycle; returns just after the accepting edge.
    task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                         input logic [2:0] ef, input logic [3:0] es, input int lat,
                         input string nm, input bit push);
        cmpIf.a = av;
        cmpIf.b = bv;
`ifdef SERIAL_CMP_SIGNED_EN
        cmpIf.sgn = sv;
`else
        if (sv) $display("note: sgn ignored in unsigned build");
`endif
        cmpIf.start = 1'b1;
        if (push) sb.push_back('{ef, es, cycCnt + 1 + lat, nm});
        @(posedge clk);
        #1;
        cmpIf.start = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to drain, then check the held result in IDLE.
    task automatic waitDone(input logic [2:0] ef, input string nm);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        #1;
        chk({nm, "_busy_after_start"}, {7'd0, cmpIf.busy}, 8'd1);
        chk({nm, "_flags_cleared"}, {5'd0, cmpIf.a_gt_b, cmpIf.a_lt_b, cmpIf.a_eq_b}, 8'd0);
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: no done within 20 cycles, required done", nm);
            sb.delete();
        end
        @(negedge clk);
        #1;
        chk({nm, "_held_flags"}, {5'd0, cmpIf.a_gt_b, cmpIf.a_lt_b, cmpIf.a_eq_b}, {5'd0, ef});
        chk({nm, "_idle_done"}, {7'd0, cmpIf.done}, 8'd0);
    endtask

    task automatic runVec(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                          input logic [2:0] ef, input logic [3:0] es, input int lat,
                          input string nm);
        issue(av, bv, sv, ef, es, lat, nm, 1'b1);
        waitDone(ef, nm);
    endtask

    initial begin
        cycCnt      = 0;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        cmpIf.start = 1'b0;
        cmpIf.a     = '0;
        cmpIf.b     = '0;
`ifdef SERIAL_CMP_SIGNED_EN
        cmpIf.sgn   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chkAllZero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Directed unsigned vectors: a, b, sgn, flags, steps, latency.
        runVec(8'h80, 8'h7F, 1'b0, XGT, 4'd1, 1, "gt_msb");
        runVec(8'h12, 8'h13, 1'b0, XLT, 4'd8, 8, "lt_lsb");
        runVec(8'hA5, 8'hA5, 1'b0, XEQ, 4'd8, 8, "eq_a5");
        runVec(8'h00, 8'hFF, 1'b0, XLT, 4'd1, 1, "lt_msb");
        runVec(8'h3C, 8'h34, 1'b0, XGT, 4'd5, 5, "gt_mid");
        runVec(8'h01, 8'h00, 1'b0, XGT, 4'd8, 8, "gt_lsb");
        runVec(8'h00, 8'h00, 1'b0, XEQ, 4'd8, 8, "eq_zero");

        // start during CMP must be ignored.
        issue(8'h12, 8'h13, 1'b0, XLT, 4'd8, 8, "ignore_start", 1'b1);
        @(posedge clk);
        #1;
        cmpIf.a     = 8'h00;
        cmpIf.b     = 8'h13;
        cmpIf.start = 1'b1;
        @(posedge clk);
        #1;
        cmpIf.start = 1'b0;
        waitDone(XLT, "ignore_start");
        repeat (4) @(negedge clk);
        #1;
        chk("ignore_start_no_extra", 8'(sb.size()), 8'd0);

        // Reset asserted at cycle 3 of a running comparison.
        issue(8'h12, 8'h13, 1'b0, XLT, 4'd8, 8, "reset_mid", 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chkAllZero("reset_mid");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        runVec(8'h40, 8'h20, 1'b0, XGT, 4'd2, 2, "after_reset");

`ifdef SERIAL_CMP_SIGNED_EN
        runVec(8'hFF, 8'h01, 1'b1, XLT, 4'd1, 1, "signed_m1_vs_1");
        runVec(8'hFF, 8'h01, 1'b0, XGT, 4'd1, 1, "unsigned_ff_vs_1");
        runVec(8'h80, 8'h7F, 1'b1, XLT, 4'd1, 1, "signed_min_vs_max");
        runVec(8'hFE, 8'hFF, 1'b1, XLT, 4'd8, 8, "signed_m2_vs_m1");
`endif

        repeat (3) @(negedge clk);
        #1;
        chk("final_queue_empty", 8'(sb.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
